// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: state sequencer, strobe decode, halt latch
// and retired-instruction counter for the multicycle CPU.
module multicycle_ctrl #(
  parameter int RETW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [5:0]      opcode,
  input  logic            zero,
  input  logic            sign,
  output logic [2:0]      state,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic            mRD,
  output logic            mWR,
  output logic [2:0]      ALUOp,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            DBDataSrc,
  output logic [1:0]      PCSrc,
  output logic            halted,
  output logic [RETW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_AE  = 3'b110,
    S_BE  = 3'b101,
    S_CE  = 3'b010,
    S_MEM = 3'b011,
    S_AWB = 3'b111,
    S_CWB = 3'b100
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t          r_state;
  state_t          w_next;
  logic            r_halted;
  logic [RETW-1:0] r_retired;

  logic w_halt;
  logic w_jmp;
  logic w_jr;
  logic w_jal;
  logic w_beq;
  logic w_bne;
  logic w_bltz;
  logic w_br;
  logic w_lw;
  logic w_sw;
  logic w_rtype;
  logic w_logi;
  logic w_imm;
  logic w_taken;
  logic w_alu_en;
  logic w_halt_set;

  assign w_halt  = (opcode == OP_HALT);
  assign w_jmp   = (opcode[5:3] == 3'b111) && !w_halt;
  assign w_jr    = (opcode == OP_JR);
  assign w_jal   = (opcode == OP_JAL);
  assign w_beq   = (opcode == OP_BEQ);
  assign w_bne   = (opcode == OP_BNE);
  assign w_bltz  = (opcode == OP_BLTZ);
  assign w_br    = w_beq | w_bne | w_bltz;
  assign w_lw    = (opcode == OP_LW);
  assign w_sw    = (opcode == OP_SW);
  assign w_rtype = (opcode == OP_ADD) | (opcode == OP_SUB) |
                   (opcode == OP_AND) | (opcode == OP_SLL) |
                   (opcode == OP_SLT);
  assign w_logi  = (opcode == OP_ANDI) | (opcode == OP_ORI) |
                   (opcode == OP_XORI);
  assign w_imm   = w_logi | (opcode == OP_ADDIU) |
                   (opcode == OP_SLTI) | w_lw | w_sw;
  assign w_taken = (w_beq & zero) | (w_bne & ~zero) |
                   (w_bltz & sign);

  // ALU-side selects idle in IF, while halted and for the halt op
  assign w_alu_en   = (r_state != S_IF) && !r_halted && !w_halt;
  assign w_halt_set = (r_state == S_ID) && w_halt;

  // state register and sticky halt latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_halt_set)
        r_halted <= 1'b1;
    end
  end

  // next-state function
  always_comb begin
    w_next = S_IF;
    if (r_halted) begin
      w_next = S_ID;
    end else begin
      unique case (r_state)
        S_IF: w_next = S_ID;
        S_ID: begin
          unique case (1'b1)
            w_halt:       w_next = S_ID;
            w_jmp:        w_next = S_IF;
            w_br:         w_next = S_BE;
            (w_lw|w_sw):  w_next = S_CE;
            default:      w_next = S_AE;
          endcase
        end
        S_AE:  w_next = S_AWB;
        S_BE:  w_next = S_IF;
        S_CE:  w_next = S_MEM;
        S_MEM: w_next = w_lw ? S_CWB : S_IF;
        S_AWB: w_next = S_IF;
        S_CWB: w_next = S_IF;
        default: w_next = S_IF;
      endcase
    end
  end

  // strobe decode from registered state and opcode
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUOp     = 3'b000;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    if (!r_halted) begin
      unique case (r_state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          PCWre  = w_jmp;
          RegWre = w_jal;
          if (w_jmp)
            PCSrc = w_jr ? 2'b10 : 2'b11;
        end
        S_BE: begin
          PCWre = 1'b1;
          PCSrc = w_taken ? 2'b01 : 2'b00;
        end
        S_MEM: begin
          PCWre = w_sw;
          mWR   = w_sw;
          mRD   = w_lw;
        end
        S_AWB: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        S_CWB: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
        end
        default: ;
      endcase
      if (RegWre) begin
        WrRegDSrc = !w_jal;
        unique case (1'b1)
          w_jal:   RegDst = 2'b10;
          w_rtype: RegDst = 2'b01;
          default: RegDst = 2'b00;
        endcase
      end
    end
    if (w_alu_en) begin
      ALUSrcA = (opcode == OP_SLL);
      ALUSrcB = w_imm;
      ExtSel  = !w_logi;
      unique case (opcode)
        OP_SUB, OP_BEQ,
        OP_BNE, OP_BLTZ:  ALUOp = 3'b001;
        OP_AND, OP_ANDI:  ALUOp = 3'b100;
        OP_ORI:           ALUOp = 3'b011;
        OP_XORI:          ALUOp = 3'b111;
        OP_SLL:           ALUOp = 3'b010;
        OP_SLT, OP_SLTI:  ALUOp = 3'b110;
        default:          ALUOp = 3'b000;
      endcase
    end
  end

  // retire counter steps on the PC-load edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_retired <= '0;
    else if (PCWre)
      r_retired <= r_retired + RETW'(1);
  end

  assign state   = r_state;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule
